// File: rtl/time_counter_bcd.sv
// time_counter_bcd: BCD hh:mm:ss time-of-day counter advanced by a 1 Hz tick strobe.
// Optional macro CLOCK_ALARM_EN adds an hh:mm alarm (alarm_set/alarm_hh/alarm_mm in, alarm out).
// Ports: clk, reset (async active-low), tick, pause, load, load_hh/mm/ss (packed BCD in),
//        hh/mm/ss (packed BCD out), min_pulse/hour_pulse/day_pulse (wrap strobes),
//        load_err (rejected load or alarm_set strobe).
module time_counter_bcd #(
    parameter int HOUR_MODULO = 24,
    parameter int RESET_HH    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse,
    output logic       load_err
`ifdef CLOCK_ALARM_EN
    ,
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic       alarm
`endif
);
    localparam logic [7:0] HMAX = (HOUR_MODULO == 12) ? 8'h11 : 8'h23;
    localparam logic [7:0] HRST = 8'((RESET_HH / 10) * 16 + RESET_HH % 10);
    // Both nibbles must be decimal digits; once they are, BCD compares like binary.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v <= max;
    endfunction
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction
    logic       w_adv, w_s_wrap, w_m_wrap, w_h_wrap, w_load_ok, w_aset_err;
    logic [7:0] w_hh_n, w_mm_n, w_ss_n;
    assign w_adv     = tick && !pause && !load;
    assign w_s_wrap  = ss == 8'h59;
    assign w_m_wrap  = w_s_wrap && mm == 8'h59;
    assign w_h_wrap  = w_m_wrap && hh == HMAX;
    assign w_ss_n    = w_s_wrap ? 8'h00 : bcd_inc(ss);
    assign w_mm_n    = w_s_wrap ? (mm == 8'h59 ? 8'h00 : bcd_inc(mm)) : mm;
    assign w_hh_n    = w_m_wrap ? (w_h_wrap ? 8'h00 : bcd_inc(hh)) : hh;
    assign w_load_ok = bcd_ok(load_hh, HMAX) && bcd_ok(load_mm, 8'h59) && bcd_ok(load_ss, 8'h59);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hh         <= HRST;
            mm         <= 8'h00;
            ss         <= 8'h00;
            min_pulse  <= 1'b0;
            hour_pulse <= 1'b0;
            day_pulse  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            min_pulse  <= w_adv && w_s_wrap;
            hour_pulse <= w_adv && w_m_wrap;
            day_pulse  <= w_adv && w_h_wrap;
            load_err   <= (load && !w_load_ok) || w_aset_err;
            if (load) begin
                if (w_load_ok) {hh, mm, ss} <= {load_hh, load_mm, load_ss};
            end else if (w_adv) begin
                {hh, mm, ss} <= {w_hh_n, w_mm_n, w_ss_n};
            end
        end
    end
`ifdef CLOCK_ALARM_EN
    logic       r_armed;
    logic [7:0] r_ahh, r_amm;
    logic       w_aset_ok;
    assign w_aset_ok  = bcd_ok(alarm_hh, HMAX) && bcd_ok(alarm_mm, 8'h59);
    assign w_aset_err = alarm_set && !w_aset_ok;
    // Only a counted advance into second 00 can fire; loads never do.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed <= 1'b0;
            r_ahh   <= 8'h00;
            r_amm   <= 8'h00;
            alarm   <= 1'b0;
        end else begin
            alarm <= r_armed && w_adv && w_s_wrap && w_hh_n == r_ahh && w_mm_n == r_amm;
            if (alarm_set && w_aset_ok) begin
                r_armed <= 1'b1;
                r_ahh   <= alarm_hh;
                r_amm   <= alarm_mm;
            end
        end
    end
`else
    assign w_aset_err = 1'b0;
`endif
endmodule
